// File: rtl/wash_phase_timer.sv
// wash_phase_timer
//   Phase timing and supervision for the washing machine sequencer. Latches a
//   wash program on start, times each phase the sequencer reports (fill,
//   wash/rinse, drain, spin), returns level timeouts for the cycle and spin
//   phases, and latches a fault on fill/drain overrun or on a phase conflict.
//
// Ports
//   clk            clock
//   reset          asynchronous, active-low reset
//   start          start request, honoured only in IDLE
//   prog [1:0]     wash program latched on accepted start (3 behaves as 0);
//                  named prog because "program" is a reserved word
//   abort          synchronous return to IDLE from any state
//   fill_active    sequencer fill phase
//   cycle_active   sequencer wash/rinse phase
//   drain_active   sequencer drain phase
//   spin_active    sequencer spin phase
//   done           sequencer finished the program
//   busy           high while ACTIVE
//   cycle_timeout  wash/rinse phase expired (level)
//   spin_timeout   spin phase expired (level)
//   fault          high while FAULT
//   fault_code     1 fill overrun, 2 drain overrun, 3 phase conflict
//   remaining      ticks left in the current phase (0 outside ACTIVE)
module wash_phase_timer #(
    parameter int TICK_DIV    = 1000,
    parameter int CNT_W       = 12,
    parameter int WASH_NORMAL = 600,
    parameter int WASH_QUICK  = 300,
    parameter int WASH_HEAVY  = 900,
    parameter int RINSE_T     = 240,
    parameter int SPIN_T      = 120,
    parameter int FILL_LIMIT  = 180,
    parameter int DRAIN_LIMIT = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       prog,
    input  logic             abort,
    input  logic             fill_active,
    input  logic             cycle_active,
    input  logic             drain_active,
    input  logic             spin_active,
    input  logic             done,
    output logic             busy,
    output logic             cycle_timeout,
    output logic             spin_timeout,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] remaining
);
    localparam int PS_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, ACTIVE, FAULT} state_t;

    state_t           state, state_nxt;
    logic [1:0]       prog_q, prog_nxt;
    logic [1:0]       cyc_cnt, cyc_cnt_nxt;   // cycle-phase entries, saturating at 2
    logic [PS_W-1:0]  presc, presc_nxt;
    logic [CNT_W-1:0] cnt_nxt;                // remaining doubles as the tick counter
    logic             cto_nxt, sto_nxt;
    logic [1:0]       code_nxt;
    logic [3:0]       phases, phase_prev;
    logic             any_phase, conflict, entry, wrap, expired;
    logic [CNT_W-1:0] entry_dur;

    function automatic logic [CNT_W-1:0] wash_dur(input logic [1:0] p);
        case (p)
            2'd1:    return CNT_W'(WASH_QUICK);
            2'd2:    return CNT_W'(WASH_HEAVY);
            default: return CNT_W'(WASH_NORMAL);
        endcase
    endfunction

    // Phase decode. Conflict is tested ahead of everything else, so the
    // entry/expiry terms below may assume at most one phase is high.
    assign phases    = {spin_active, drain_active, cycle_active, fill_active};
    assign any_phase = |phases;
    assign conflict  = (phases & (phases - 4'd1)) != 4'd0;
    assign entry     = |(phases & ~phase_prev);
    assign wrap      = presc == PS_W'(TICK_DIV - 1);
    assign expired   = any_phase && !entry && (remaining == '0);

    always_comb begin
        entry_dur = '0;
        if (fill_active)
            entry_dur = CNT_W'(FILL_LIMIT);
        else if (cycle_active)
            entry_dur = (cyc_cnt == 2'd0) ? wash_dur(prog_q) : CNT_W'(RINSE_T);
        else if (drain_active)
            entry_dur = CNT_W'(DRAIN_LIMIT);
        else if (spin_active)
            entry_dur = CNT_W'(SPIN_T);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:
                if (start && !abort) state_nxt = ACTIVE;
            ACTIVE:
                if (abort)
                    state_nxt = IDLE;
                else if (conflict)
                    state_nxt = FAULT;
                else if (done)
                    state_nxt = IDLE;
                else if (expired && (fill_active || drain_active))
                    state_nxt = FAULT;
            FAULT:
                if (abort) state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values; everything lands in registers below.
    always_comb begin
        prog_nxt    = prog_q;
        cyc_cnt_nxt = cyc_cnt;
        presc_nxt   = presc;
        cnt_nxt     = remaining;
        cto_nxt     = 1'b0;
        sto_nxt     = 1'b0;
        code_nxt    = fault_code;
        unique case (state)
            IDLE: begin
                cnt_nxt  = '0;
                code_nxt = 2'd0;
                if (start && !abort) begin
                    prog_nxt    = prog;
                    cyc_cnt_nxt = 2'd0;
                    presc_nxt   = '0;
                end
            end
            ACTIVE: begin
                if (abort || conflict || done) begin
                    cnt_nxt = '0;
                    if (!abort && conflict) code_nxt = 2'd3;
                end else if (entry) begin
                    cnt_nxt   = entry_dur;
                    presc_nxt = '0;
                    if (cycle_active && cyc_cnt != 2'd2) cyc_cnt_nxt = cyc_cnt + 2'd1;
                end else if (any_phase) begin
                    presc_nxt = wrap ? '0 : presc + 1'b1;
                    if (wrap && remaining != '0) cnt_nxt = remaining - 1'b1;
                    // Expiry: the counter already sat at 0 entering this edge.
                    if (remaining == '0) begin
                        cto_nxt = cycle_active;
                        sto_nxt = spin_active;
                        if (fill_active)  code_nxt = 2'd1;
                        if (drain_active) code_nxt = 2'd2;
                    end
                end
                // No phase high: counter and prescaler hold, timeouts drop.
            end
            FAULT: begin
                cnt_nxt = '0;
                if (abort) code_nxt = 2'd0;
            end
            default: begin
                cnt_nxt  = '0;
                code_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog_q        <= 2'd0;
            cyc_cnt       <= 2'd0;
            presc         <= '0;
            remaining     <= '0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            fault_code    <= 2'd0;
            busy          <= 1'b0;
            fault         <= 1'b0;
            phase_prev    <= 4'd0;
        end else begin
            prog_q        <= prog_nxt;
            cyc_cnt       <= cyc_cnt_nxt;
            presc         <= presc_nxt;
            remaining     <= cnt_nxt;
            cycle_timeout <= cto_nxt;
            spin_timeout  <= sto_nxt;
            fault_code    <= code_nxt;
            busy          <= (state_nxt == ACTIVE);
            fault         <= (state_nxt == FAULT);
            phase_prev    <= phases;
        end
    end
endmodule

// File: tb/tb_wash_phase_timer.sv
// Testbench for wash_phase_timer: directed scenarios with hand-computed
// expectations, then randomized phase traffic checked every cycle against a
// behavioural model that tracks elapsed cycles per phase.
module tb_wash_phase_timer;
    localparam int TD = 4, CW = 12;
    localparam int WN = 4, WQ = 3, WH = 6, RT = 2, ST = 2, FL = 5, DL = 5;
    localparam int S_IDLE = 0, S_ACT = 1, S_FLT = 2;

    logic clk = 1'b0, reset = 1'b0;
    logic start = 1'b0, abort = 1'b0, done = 1'b0;
    logic fill = 1'b0, cyc = 1'b0, drain = 1'b0, spin = 1'b0;
    logic [1:0] prog = 2'd0;
    logic busy, cto, sto, fault;
    logic [1:0] fault_code;
    logic [CW-1:0] remaining;

    int vectors = 0, miscompares = 0;

    wash_phase_timer #(
        .TICK_DIV(TD), .CNT_W(CW), .WASH_NORMAL(WN), .WASH_QUICK(WQ),
        .WASH_HEAVY(WH), .RINSE_T(RT), .SPIN_T(ST), .FILL_LIMIT(FL), .DRAIN_LIMIT(DL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .prog(prog), .abort(abort),
        .fill_active(fill), .cycle_active(cyc), .drain_active(drain),
        .spin_active(spin), .done(done), .busy(busy), .cycle_timeout(cto),
        .spin_timeout(sto), .fault(fault), .fault_code(fault_code),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    // Model: phase time is tracked as elapsed active cycles since entry;
    // ticks left = duration - elapsed/TD, floored at 0.
    typedef struct {
        int st; int prog; int entries; int dur; int el;
        int cto; int sto; int fcode; logic [3:0] prev;
    } mdl_t;

    mdl_t m;

    function automatic int rem_of(mdl_t x);
        if (x.st == S_ACT && x.dur > x.el / TD) return x.dur - x.el / TD;
        return 0;
    endfunction

    function automatic int wash_of(int p);
        if (p == 1) return WQ;
        if (p == 2) return WH;
        return WN;
    endfunction

    function automatic mdl_t step(mdl_t x, logic [3:0] ph, logic s, logic ab,
                                  logic dn, logic [1:0] pg);
        mdl_t n;
        int left, np;
        logic ent;
        n = x;
        left = rem_of(x);
        np = $countones(ph);
        ent = |(ph & ~x.prev);
        n.cto = 0;
        n.sto = 0;
        case (x.st)
            S_IDLE:
                if (s && !ab) begin
                    n.st = S_ACT; n.prog = (pg == 2'd3) ? 0 : int'(pg);
                    n.entries = 0; n.el = 0;
                end
            S_ACT:
                if (ab) n.st = S_IDLE;
                else if (np > 1) begin n.st = S_FLT; n.fcode = 3; end
                else if (dn) n.st = S_IDLE;
                else if (ent) begin
                    n.el = 0;
                    if (ph[0]) n.dur = FL;
                    if (ph[1]) begin
                        n.dur = (x.entries == 0) ? wash_of(x.prog) : RT;
                        n.entries = (x.entries < 2) ? x.entries + 1 : 2;
                    end
                    if (ph[2]) n.dur = DL;
                    if (ph[3]) n.dur = ST;
                end else if (np == 1) begin
                    n.el = x.el + 1;
                    if (left == 0) begin
                        if (ph[0]) begin n.st = S_FLT; n.fcode = 1; end
                        if (ph[2]) begin n.st = S_FLT; n.fcode = 2; end
                        n.cto = int'(ph[1]);
                        n.sto = int'(ph[3]);
                    end
                end
            default:
                if (ab) begin n.st = S_IDLE; n.fcode = 0; end
        endcase
        if (n.st != S_ACT) begin n.dur = 0; n.el = 0; end
        n.prev = ph;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '{default: 0};
        else m <= step(m, {spin, drain, cyc, fill}, start, abort, done, prog);
    end

    task automatic cmp_model();
        logic [CW+5:0] got, want;
        got  = {busy, cto, sto, fault, fault_code, remaining};
        want = {m.st == S_ACT, m.cto[0], m.sto[0], m.st == S_FLT,
                2'(m.fcode), CW'(rem_of(m))};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL model_cmp t=%0t got b/ct/st/f/fc/rem=%0b/%0b/%0b/%0b/%0d/%0d want %0b/%0b/%0b/%0b/%0d/%0d",
                     $time, got[CW+5], got[CW+4], got[CW+3], got[CW+2], got[CW+1:CW], got[CW-1:0],
                     want[CW+5], want[CW+4], want[CW+3], want[CW+2], want[CW+1:CW], want[CW-1:0]);
        end
    endtask

    task automatic lit(string nm, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_model();
    endtask

    function automatic int outs();
        return int'({busy, cto, sto, fault, fault_code, remaining});
    endfunction

    task automatic do_start(logic [1:0] p);
        prog = p; start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    initial begin
        logic [3:0] ph;
        int cur;
        #2;
        lit("reset_outs", outs(), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Quick program, wash phase: 3 ticks * 4 = 12 cycles, timeout after N+13
        do_start(2'd1);
        lit("busy_rise", busy, 1);
        cyc = 1'b1;
        tick();
        lit("rem_load_quick", remaining, 3);
        repeat (12) tick();
        lit("cto_before", cto, 0);
        lit("rem_zero", remaining, 0);
        tick();
        lit("cto_rise", cto, 1);
        cyc = 1'b0;
        tick();
        lit("cto_fall", cto, 0);
        done = 1'b1; tick(); done = 1'b0;
        lit("busy_fall_1", busy, 0);

        // Full program
        do_start(2'd1);
        fill = 1'b1;  repeat (8) tick();
        fill = 1'b0; cyc = 1'b1; repeat (16) tick();
        cyc = 1'b0; drain = 1'b1; repeat (6) tick();
        drain = 1'b0; fill = 1'b1; repeat (6) tick();
        fill = 1'b0; cyc = 1'b1; tick();
        lit("rinse_load", remaining, RT);
        repeat (8) tick();
        lit("rinse_pre", cto, 0);
        tick();
        lit("rinse_to", cto, 1);
        repeat (2) tick();
        cyc = 1'b0; drain = 1'b1; repeat (6) tick();
        drain = 1'b0; spin = 1'b1; repeat (9) tick();
        lit("spin_pre", sto, 0);
        tick();
        lit("spin_to", sto, 1);
        spin = 1'b0; done = 1'b1; tick(); done = 1'b0;
        lit("busy_fall_2", busy, 0);

        // Fill overrun: 5 ticks * 4 = 20, fault visible after N+21
        do_start(2'd0);
        fill = 1'b1;
        repeat (21) tick();
        lit("fill_pre", fault, 0);
        tick();
        lit("fill_fault", int'({fault, fault_code}), 5);
        lit("fill_busy", busy, 0);
        repeat (3) tick();
        fill = 1'b0;
        do_abort();
        lit("abort_clear", outs(), 0);

        // Phase conflict, start ignored in FAULT
        do_start(2'd0);
        cyc = 1'b1; drain = 1'b1;
        tick();
        lit("conflict", int'({fault, fault_code}), 7);
        cyc = 1'b0; drain = 1'b0;
        do_start(2'd2);
        lit("start_in_fault", int'({busy, fault, fault_code}), 7);
        do_abort();

        // Hold on drop, reload on re-entry
        do_start(2'd0);
        fill = 1'b1;
        tick();
        lit("fill_load", remaining, FL);
        repeat (12) tick();
        lit("rem_two", remaining, 2);
        fill = 1'b0;
        repeat (4) tick();
        lit("rem_hold", remaining, 2);
        fill = 1'b1;
        tick();
        lit("reload", remaining, FL);
        fill = 1'b0;
        do_abort();

        // Reset mid-spin, then program 3 behaves as normal
        do_start(2'd2);
        spin = 1'b1;
        repeat (3) tick();
        #1 reset = 1'b0;
        #1 lit("reset_mid", outs(), 0);
        spin = 1'b0;
        tick();
        reset = 1'b1;
        do_start(2'd3);
        cyc = 1'b1;
        tick();
        lit("prog3_normal", remaining, WN);
        cyc = 1'b0;
        done = 1'b1; tick(); done = 1'b0;

        // Randomized traffic
        cur = 4;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) cur = int'($urandom_range(0, 4));
            ph = (cur < 4) ? 4'(1 << cur) : 4'd0;
            if ($urandom_range(0, 199) == 0) ph = ph | 4'(1 << $urandom_range(0, 3));
            {spin, drain, cyc, fill} = ph;
            start = ($urandom_range(0, 15) == 0);
            prog  = 2'($urandom_range(0, 3));
            done  = ($urandom_range(0, 99) == 0);
            abort = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 799) != 0);
            tick();
        end
        reset = 1'b1;
        {spin, drain, cyc, fill} = 4'd0;
        start = 1'b0; done = 1'b0; abort = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Timing and supervision controller for the automatic washing machine sequencer. It latches a wash program at start and times each active phase the sequencer reports: wash, rinse, spin, fill and drain. It returns level timeouts (`cycle_timeout`, `spin_timeout`) to the sequencer and raises a latched fault when a fill or drain overruns its limit. It sits beside the sequencer FSM and replaces externally supplied timeout inputs.

## Interface
- `TICK_DIV`, 1000: clk cycles per time tick; legal range ≥ 2.
- `CNT_W`, 12: width of the tick counter and of `remaining`.
- `WASH_NORMAL`, 600: soap-wash duration in ticks, program 0.
- `WASH_QUICK`, 300: soap-wash duration in ticks, program 1.
- `WASH_HEAVY`, 900: soap-wash duration in ticks, program 2.
- `RINSE_T`, 240: rinse (second cycle phase) duration in ticks, all programs.
- `SPIN_T`, 120: spin duration in ticks.
- `FILL_LIMIT`, 180: maximum fill duration in ticks before fault.
- `DRAIN_LIMIT`, 120: maximum drain duration in ticks before fault.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `start`  in  1  start request; sampled only in IDLE.
- `program`  in  2  wash program, latched on accepted start; value 3 is treated as 0.
- `abort`  in  1  synchronous return to IDLE from any state.
- `fill_active`  in  1  sequencer is in its fill phase.
- `cycle_active`  in  1  sequencer is in its wash/rinse phase.
- `drain_active`  in  1  sequencer is in its drain phase.
- `spin_active`  in  1  sequencer is in its spin phase.
- `done`  in  1  sequencer has finished the program.
- `busy`  out  1  high in ACTIVE.
- `cycle_timeout`  out  1  level; high while the wash/rinse phase has expired.
- `spin_timeout`  out  1  level; high while the spin phase has expired.
- `fault`  out  1  high in FAULT.
- `fault_code`  out  2  1 = fill overrun, 2 = drain overrun, 3 = phase conflict, 0 = none.
- `remaining`  out  `CNT_W`  ticks left in the current phase.

## Operation
- States: IDLE, ACTIVE, FAULT. Reset enters IDLE with every output 0, the prescaler at 0 and the cycle-entry count at 0.
- IDLE:
  - Phase inputs and `done` are ignored.
  - When `start` = 1 and `abort` = 0: latch `program`, clear the cycle-entry count, go to ACTIVE.
- ACTIVE, phase entry:
  - An entry is a phase input that is 1 this cycle and was 0 the previous cycle.
  - On entry, load the counter with that phase's duration, clear the prescaler and clear both timeouts.
  - Durations: fill = `FILL_LIMIT`; first cycle entry = wash time of the latched program; second and later cycle entries = `RINSE_T`; drain = `DRAIN_LIMIT`; spin = `SPIN_T`.
  - The cycle-entry count saturates at 2.
- ACTIVE, counting:
  - The prescaler increments each cycle a phase is active and wraps at `TICK_DIV`-1.
  - On the wrap, the counter decrements if it is non-zero.
  - The counter holds at 0.
- ACTIVE, expiry: counter = 0 with the phase still active.
  - Cycle phase: `cycle_timeout` = 1 until `cycle_active` falls.
  - Spin phase: `spin_timeout` = 1 until `spin_active` falls.
  - Fill phase: go to FAULT, `fault_code` = 1.
  - Drain phase: go to FAULT, `fault_code` = 2.
- ACTIVE, phase conflict: more than one phase input high in the same cycle → FAULT, `fault_code` = 3. This check has priority over entry and expiry.
- ACTIVE, no phase input high: the counter and prescaler hold, and `remaining` shows the held value.
- ACTIVE, `done` = 1: go to IDLE, clear the timeouts and `remaining`.
- FAULT:
  - `fault` = 1 and `fault_code` holds.
  - The timeouts are 0 and `busy` = 0.
  - Stays in FAULT until `abort` or reset; `start` is ignored.
- Priority, highest first: reset, `abort`, conflict, `done`, expiry, normal counting.
- `start` while ACTIVE is ignored, and the latched program is unchanged.
- `remaining` equals the counter in ACTIVE and is 0 in IDLE and FAULT.

## Timing
- All outputs are registered.
- Phase input first sampled high at edge N, with duration D:
  - the counter reaches 0 at edge N + D·`TICK_DIV`;
  - the timeout or fault is visible after edge N + D·`TICK_DIV` + 1.
  - D = 0 gives visibility after edge N + 1.
- Timeouts fall one edge after the phase input is sampled low.
- `busy` rises one edge after `start` is accepted and falls one edge after `done` or `abort` is sampled.
- Asserting `reset` mid-phase clears everything asynchronously; operation resumes in IDLE.

## Test plan
Bench parameters: `TICK_DIV`=4, `WASH_QUICK`=3, `RINSE_T`=2, `SPIN_T`=2, `FILL_LIMIT`=5, `DRAIN_LIMIT`=5.
- `start` with `program`=1, then `cycle_active` held from edge N → `cycle_timeout` high after edge N+13; it drops one edge after `cycle_active` falls.
- Full program: fill, cycle, drain, fill, cycle, drain, spin, `done` → second cycle times out after 8 cycles, spin after 8; `busy` returns to 0 after `done`.
- `fill_active` held for 25 cycles → `fault`=1, `fault_code`=1 after edge N+21; `abort` → IDLE with all outputs 0.
- `cycle_active` and `drain_active` high together → `fault_code`=3 one edge later; `start` in FAULT is ignored.
- Phase drops mid-count with `remaining`=2 → `remaining` holds at 2; re-entering the same phase reloads the full duration.
- `reset` low mid-spin → all outputs 0 immediately; `program`=3 on the next start uses `WASH_NORMAL`.
